// File: rtl/mmio_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_port_pkg
// Purpose  : Shared constants for the MMIO port responder: word offsets of
//            the register window, STATUS bit positions and reset values.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_port_pkg;

  // Word offsets within the 32-byte window (Address[4:2])
  localparam logic [2:0] OFF_PORT_OUT = 3'd0;  // 0x00
  localparam logic [2:0] OFF_PORT_IN  = 3'd1;  // 0x04
  localparam logic [2:0] OFF_EDGE     = 3'd2;  // 0x08
  localparam logic [2:0] OFF_COUNT    = 3'd3;  // 0x0C
  localparam logic [2:0] OFF_COMPARE  = 3'd4;  // 0x10
  localparam logic [2:0] OFF_STATUS   = 3'd5;  // 0x14

  // STATUS register bit positions
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_EN_BIT    = 1;

  // COMPARE comes out of reset at its maximum value
  localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

endpackage : mmio_port_pkg
`default_nettype wire

// File: rtl/port_in_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : port_in_sync_edge
// Purpose  : Two-flop synchronizer for the external input port, a history
//            register, and a bank of sticky edge flags cleared by W1C.
// Revision : 1.0 - initial release
// ============================================================================
module port_in_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic [WIDTH-1:0] port_i,     // asynchronous external inputs
  input  logic [WIDTH-1:0] w1c_i,      // one-cycle clear mask from a store
  output logic [WIDTH-1:0] synced_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync0_q;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;

  // Hardware set takes priority over a software clear of the same bit
  always_comb begin
    edge_d = (edge_q & ~w1c_i) | (sync1_q ^ prev_q);
  end

  // Synchronizer chain, history register and edge flags; prev starts at 0 so
  // an input already high at reset release is reported as a rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
    end else begin
      sync0_q <= port_i;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
      edge_q  <= edge_d;
    end
  end

  assign synced_o = sync1_q;
  assign edge_o   = edge_q;

endmodule : port_in_sync_edge
`default_nettype wire

// File: rtl/mmio_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_port_responder
// Purpose  : Single-cycle MMIO slave on the data-memory bus. Owns the output
//            port register, the synchronized/edge-flagged input port and a
//            free-running compare timer with a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_port_responder
  import mmio_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS  = 32'hFFFF_0000,
  parameter int          PORT_IN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,     // asynchronous, active-low
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [31:0]              Address,
  input  logic [31:0]              WriteData,
  output logic [31:0]              ReadData,
  output logic                     Selected,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0]              PortOut,
  output logic                     TimerIrq
);

  logic [2:0]               w_off;
  logic                     w_wr;
  logic [PORT_IN_WIDTH-1:0] w_edge_w1c;
  logic [PORT_IN_WIDTH-1:0] w_synced;
  logic [PORT_IN_WIDTH-1:0] w_edge;
  logic [31:0]              w_port_in_ext;
  logic [31:0]              w_edge_ext;
  logic                     w_match_evt;
  logic [31:0]              w_rd_mux;

  logic [31:0] port_out_q, port_out_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic        match_q,    match_d;
  logic        en_q,       en_d;

  // Only the exact 32-byte window decodes; the byte lane bits are ignored
  assign Selected = (Address[31:5] == BASE_ADDRESS[31:5]);
  assign w_off    = Address[4:2];
  assign w_wr     = MemWrite && Selected;

  // Address[1:0] and the upper store bits of narrow registers are don't-care
  logic w_unused_bits;
  assign w_unused_bits = ^{Address[1:0], WriteData[31:2]};

  // Store to EDGE produces a one-cycle clear mask for the flag bank
  always_comb begin
    w_edge_w1c = '0;
    if (w_wr && (w_off == OFF_EDGE)) begin
      w_edge_w1c = WriteData[PORT_IN_WIDTH-1:0];
    end
  end

  port_in_sync_edge #(
    .WIDTH (PORT_IN_WIDTH)
  ) u_port_in (
    .clk      (clk),
    .reset    (reset),
    .port_i   (PortIn),
    .w1c_i    (w_edge_w1c),
    .synced_o (w_synced),
    .edge_o   (w_edge)
  );

  // Zero-extend the narrow input-port views to the bus width
  always_comb begin
    w_port_in_ext                    = '0;
    w_edge_ext                       = '0;
    w_port_in_ext[PORT_IN_WIDTH-1:0] = w_synced;
    w_edge_ext[PORT_IN_WIDTH-1:0]    = w_edge;
  end

  // Match fires only while the timer is enabled and uses the current COMPARE
  assign w_match_evt = en_q && (count_q == compare_q);

  // Next-state for the output port, timer and STATUS with bus-write priority
  always_comb begin
    port_out_d = port_out_q;
    compare_d  = compare_q;
    en_d       = en_q;
    count_d    = count_q;
    match_d    = match_q;

    if (en_q) begin
      count_d = w_match_evt ? 32'd0 : count_q + 32'd1;
    end

    if (w_wr) begin
      case (w_off)
        OFF_PORT_OUT: port_out_d = WriteData;
        OFF_COUNT:    count_d    = WriteData;
        OFF_COMPARE:  compare_d  = WriteData;
        OFF_STATUS: begin
          en_d = WriteData[STATUS_EN_BIT];
          if (WriteData[STATUS_MATCH_BIT]) begin
            match_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A match event overrides a same-cycle clear of the match flag
    if (w_match_evt) begin
      match_d = 1'b1;
    end
  end

  // Architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q <= '0;
      count_q    <= '0;
      compare_q  <= COMPARE_RESET;
      match_q    <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      port_out_q <= port_out_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      en_q       <= en_d;
    end
  end

  // Combinational read mux; reads have no side effects
  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_PORT_OUT: w_rd_mux = port_out_q;
      OFF_PORT_IN:  w_rd_mux = w_port_in_ext;
      OFF_EDGE:     w_rd_mux = w_edge_ext;
      OFF_COUNT:    w_rd_mux = count_q;
      OFF_COMPARE:  w_rd_mux = compare_q;
      OFF_STATUS: begin
        w_rd_mux[STATUS_MATCH_BIT] = match_q;
        w_rd_mux[STATUS_EN_BIT]    = en_q;
      end
      default:      w_rd_mux = '0;
    endcase
  end

  assign ReadData = (MemRead && Selected) ? w_rd_mux : 32'd0;
  assign PortOut  = port_out_q;
  assign TimerIrq = match_q;

endmodule : mmio_port_responder
`default_nettype wire

// File: tb/tb_mmio_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_port_responder
// Purpose  : Directed self-checking bench for mmio_port_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_port_responder;

  localparam logic [31:0] A_PORT_OUT = 32'hFFFF_0000;
  localparam logic [31:0] A_PORT_IN  = 32'hFFFF_0004;
  localparam logic [31:0] A_EDGE     = 32'hFFFF_0008;
  localparam logic [31:0] A_COUNT    = 32'hFFFF_000C;
  localparam logic [31:0] A_COMPARE  = 32'hFFFF_0010;
  localparam logic [31:0] A_STATUS   = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic        Selected;
  logic [7:0]  PortIn = 8'h00;
  logic [31:0] PortOut;
  logic        TimerIrq;

  int n_assert = 0;
  int n_fail   = 0;

  mmio_port_responder #(
    .BASE_ADDRESS  (32'hFFFF_0000),
    .PORT_IN_WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Selected  (Selected),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .TimerIrq  (TimerIrq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store: set up at negedge, commit on the following posedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  // Load: combinational, sampled 1 ns after presenting the address
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a;
    MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- Reset values ----------------
    #22;
    reset = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_port_out", A_PORT_OUT, 32'h0);
    rd_chk("rst_compare",  A_COMPARE,  32'hFFFF_FFFF);
    rd_chk("rst_status",   A_STATUS,   32'h0);
    chk("rst_portout_pin", PortOut, 32'h0);
    chk("rst_irq", {31'd0, TimerIrq}, 32'h0);

    // ---------------- Port out, read-during-write shows old value ----------------
    @(negedge clk);
    Address = A_PORT_OUT; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    chk("rdw_old_value", ReadData, 32'h0);
    @(posedge clk); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("portout_pin", PortOut, 32'hDEAD_BEEF);
    rd_chk("portout_rd", A_PORT_OUT, 32'hDEAD_BEEF);

    // ---------------- Input synchronizer and edge flags ----------------
    @(negedge clk); PortIn = 8'hA5;
    @(posedge clk); #1;                        // edge N
    rd_chk("pin_after_N",    A_PORT_IN, 32'h0);
    @(posedge clk); #1;                        // edge N+1
    rd_chk("pin_after_N1",   A_PORT_IN, 32'hA5);
    rd_chk("edge_after_N1",  A_EDGE,    32'h0);
    @(posedge clk); #1;                        // edge N+2
    rd_chk("edge_after_N2",  A_EDGE,    32'hA5);
    rd_chk("edge_rd_no_clr", A_EDGE,    32'hA5);
    wr(A_EDGE, 32'h05);
    rd_chk("edge_w1c",       A_EDGE,    32'hA0);

    // ---------------- Edge set/clear collision ----------------
    @(negedge clk); PortIn = 8'hA4;
    repeat (3) @(posedge clk);
    #1;
    rd_chk("edge_bit0_set",  A_EDGE, 32'hA1);
    @(negedge clk); PortIn = 8'hA5;            // set lands on the 3rd posedge
    @(posedge clk);
    @(posedge clk);
    wr(A_EDGE, 32'h01);                        // commits on that same 3rd posedge
    rd_chk("edge_collide",   A_EDGE, 32'hA1);
    wr(A_EDGE, 32'hA1);
    rd_chk("edge_clr_all",   A_EDGE, 32'h0);

    // ---------------- Decode ----------------
    Address = 32'hFFFF_0018; MemRead = 1'b1; #1;
    chk("dec_18_data", ReadData, 32'h0);
    chk("dec_18_sel",  {31'd0, Selected}, 32'h1);
    Address = 32'hFFFF_0020; #1;
    chk("dec_20_sel",  {31'd0, Selected}, 32'h0);
    chk("dec_20_data", ReadData, 32'h0);
    Address = 32'hFFFF_0001; #1;               // byte lanes ignored
    chk("dec_bytelane", ReadData, 32'hDEAD_BEEF);
    MemRead = 1'b0;
    wr(A_PORT_IN, 32'h0000_0012);
    rd_chk("dec_ro_write",  A_PORT_IN,  32'hA5);
    wr(32'hFFFF_0020, 32'h0);
    rd_chk("dec_no_alias",  A_PORT_OUT, 32'hDEAD_BEEF);

    // ---------------- Timer ----------------
    wr(A_COMPARE, 32'd3);
    wr(A_STATUS,  32'h2);                      // enable from the next edge
    rd_chk("tmr_cnt0", A_COUNT, 32'd0);
    @(posedge clk); #1; rd_chk("tmr_cnt1", A_COUNT, 32'd1);
    @(posedge clk); #1; rd_chk("tmr_cnt2", A_COUNT, 32'd2);
    @(posedge clk); #1; rd_chk("tmr_cnt3", A_COUNT, 32'd3);
    chk("tmr_irq_pre", {31'd0, TimerIrq}, 32'h0);
    @(posedge clk); #1; rd_chk("tmr_wrap", A_COUNT, 32'd0);
    rd_chk("tmr_status_match", A_STATUS, 32'h3);
    chk("tmr_irq", {31'd0, TimerIrq}, 32'h1);
    wr(A_STATUS, 32'h3);                       // count 0->1 here, no match
    rd_chk("tmr_w1c_status", A_STATUS, 32'h2);
    chk("tmr_irq_clr", {31'd0, TimerIrq}, 32'h0);
    rd_chk("tmr_cnt_after", A_COUNT, 32'd1);
    @(posedge clk);                            // 1->2
    @(posedge clk);                            // 2->3
    wr(A_STATUS, 32'h3);                       // 3->0 with match on this edge
    rd_chk("tmr_w1c_collide", A_STATUS, 32'h3);
    rd_chk("tmr_cnt_wrap2",   A_COUNT,  32'd0);
    wr(A_STATUS, 32'h1);                       // disable and clear; count 0->1
    repeat (3) @(posedge clk);
    #1;
    rd_chk("tmr_hold",        A_COUNT,  32'd1);
    rd_chk("tmr_disabled",    A_STATUS, 32'h0);
    wr(A_COUNT, 32'd7);
    rd_chk("tmr_sw_count",    A_COUNT,  32'd7);

    // ---------------- Asynchronous reset mid-operation ----------------
    wr(A_PORT_OUT, 32'h55);
    wr(A_COMPARE,  32'd100);
    wr(A_STATUS,   32'h2);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_portout_pin", PortOut, 32'h0);
    rd_chk("arst_port_out", A_PORT_OUT, 32'h0);
    rd_chk("arst_count",    A_COUNT,    32'h0);
    rd_chk("arst_compare",  A_COMPARE,  32'hFFFF_FFFF);
    rd_chk("arst_status",   A_STATUS,   32'h0);
    rd_chk("arst_port_in",  A_PORT_IN,  32'h0);
    rd_chk("arst_edge",     A_EDGE,     32'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    rd_chk("rel_pin_R1",  A_PORT_IN, 32'h0);
    @(posedge clk); #1;
    rd_chk("rel_pin_R2",  A_PORT_IN, 32'hA5);
    rd_chk("rel_edge_R2", A_EDGE,    32'h0);
    @(posedge clk); #1;
    rd_chk("rel_edge_R3", A_EDGE,    32'hA5);
    rd_chk("rel_count",   A_COUNT,   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mmio_port_responder
`default_nettype wire

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
Memory-mapped I/O responder that answers the processor's load/store requests on the data-memory bus. It owns the external output port register, a synchronized and edge-flagged view of the 8-bit input port, and a free-running compare timer. Every access completes in one cycle: reads are combinational and writes land on the next rising edge. The top level muxes ReadData onto the load path whenever Selected is high.

Parameters:
BASE_ADDRESS, 32'hFFFF_0000, base of the 32-byte register window; bits [4:0] must be zero.
PORT_IN_WIDTH, 8, width of the external input port.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
MemRead  input  1  load request this cycle.
MemWrite  input  1  store request this cycle.
Address  input  32  byte address from ALU result.
WriteData  input  32  store data (rt).
ReadData  output  32  load data; combinational.
Selected  output  1  Address is inside the window (Address[31:5]==BASE_ADDRESS[31:5]).
PortIn  input  PORT_IN_WIDTH  asynchronous external inputs.
PortOut  output  32  registered output port.
TimerIrq  output  1  level copy of STATUS.match.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset). It is the only reset; there is no synchronous clear.
- Reset values: PortOut=0, sync stages=0, EDGE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, TimerIrq=0. ReadData follows its combinational rule.
- Decode: Address[1:0] ignored (word access only). Offset = Address[4:2].
  - 0x00 PORT_OUT RW.
  - 0x04 PORT_IN RO (zero-extended synced value).
  - 0x08 EDGE RW1C [7:0].
  - 0x0C COUNT RW.
  - 0x10 COMPARE RW.
  - 0x14 STATUS: bit0 match RW1C, bit1 enable RW.
  - 0x18, 0x1C: read 0, writes ignored.
- ReadData = selected register when MemRead && Selected, else 0. A read returns the pre-edge value; a read never clears anything.
- Writes take effect when MemWrite && Selected, on the rising edge. Writes to RO offsets are ignored. MemRead && MemWrite together: the write executes, and ReadData shows the old value.
- Input path: two-flop synchronizer sync0->sync1, plus prev<=sync1.
  - A PortIn change that is stable before edge N appears in PORT_IN after edge N+1.
  - The corresponding EDGE bit sets after edge N+2, when sync1!=prev for that bit.
- EDGE priority: a hardware set wins over a software W1C in the same cycle.
- Timer, when STATUS.enable=1:
  - Each cycle, COUNT<=COUNT+1, wrapping 32'hFFFF_FFFF->0.
  - If COUNT==COMPARE, then COUNT<=0 and match<=1 on that edge.
  - COUNT therefore cycles through 0..COMPARE (period COMPARE+1).
- Timer, when enable=0: COUNT holds; no match events.
- Timer priority, per edge:
  - A software write to COUNT beats both increment and reload.
  - A match event beats a W1C of match in the same cycle.
  - A write to COMPARE takes effect for comparisons from the next cycle.
- TimerIrq = STATUS.match (registered, no extra delay).
- Reset mid-operation: all state returns to reset values immediately, independent of clk. A partially synchronized input restarts from 0. After reset deassertion, a PortIn that is already nonzero produces EDGE bits for the 0->value transition.
- Address wrap: only the exact 32-byte window is decoded. No aliasing outside it.

Decomposition:
- Package mmio_port_pkg holds:
  - offset constants: OFF_PORT_OUT, OFF_PORT_IN, OFF_EDGE, OFF_COUNT, OFF_COMPARE, OFF_STATUS;
  - STATUS bit indices: STATUS_MATCH_BIT=0, STATUS_EN_BIT=1;
  - COMPARE_RESET=32'hFFFF_FFFF.
- One sub-module, port_in_sync_edge: parameterized width; contains the synchronizer, prev register and edge-flag bank with W1C input. Outputs the synced value and the flags.
- Timer and register decode stay in the top.

Test Plan:
- Reset check: assert reset low mid-cycle with PORT_OUT=0x55 and COUNT running -> all registers read 0 immediately, except COMPARE which reads 0xFFFFFFFF; PortOut=0.
- Port out: sw 0xDEADBEEF to 0xFFFF0000 -> PortOut=0xDEADBEEF after that edge; a read of the same offset in the same cycle returns the old value 0.
- Input sync: PortIn 0x00->0xA5 before edge N -> PORT_IN reads 0xA5 after edge N+1; EDGE reads 0xA5 after edge N+2. Then W1C 0x05 -> EDGE=0xA0.
- Edge set/clear collision: W1C of EDGE bit0 in the same cycle that bit0 toggles again -> bit0 remains 1.
- Timer: COMPARE=3, STATUS=0x2 -> COUNT sequence 0,1,2,3,0; match=1 and TimerIrq=1 after the 3->0 edge. W1C STATUS 0x3 in a non-match cycle -> match=0 and enable stays 1. W1C coinciding with a match -> match stays 1.
- Decode: lw 0xFFFF0018 -> 0 with Selected=1; lw 0xFFFF0020 -> Selected=0, ReadData=0; sw 0xFFFF0004 -> PORT_IN unaffected.
